// File: rtl/imu_ptch_intf.sv
// IMU pitch front end: configures the IMU over SPI, then reads pitch rate and Z accel per data-ready and fuses a pitch estimate.
// Latency 3 sync cycles + 4 SPI reads + 1; each SPI step waits on done, no other backpressure.
module imu_ptch_intf #(
  parameter int          INIT_BITS      = 16,
  parameter logic [15:0] PTCH_RT_OFFSET = 16'h0050,
  parameter logic [15:0] AZ_OFFSET      = 16'h00A0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               INT,
  input  logic               done,
  input  logic [15:0]        resp,
  output logic               wrt,
  output logic [15:0]        cmd,
  output logic signed [15:0] ptch_rt,
  output logic signed [15:0] ptch,
  output logic               vld
);

  typedef enum logic [3:0] {
    INIT, CFG1, CFG2, CFG3, WAIT_INT, RD_RTL, RD_RTH, RD_AZL, RD_AZH, UPDATE
  } state_t;

  state_t                 state_q, state_d;
  logic [INIT_BITS-1:0]   timer_q, timer_d, timer_nxt;
  logic                   timer_full;
  logic                   int_ff1_q, int_ff2_q, int_ff3_q, int_rise;
  logic                   wrt_q, wrt_d;
  logic [15:0]            cmd_q, cmd_d;
  logic [7:0]             rate_lo_q, rate_lo_d, rate_hi_q, rate_hi_d;
  logic [7:0]             az_lo_q, az_lo_d, az_hi_q, az_hi_d;
  logic [15:0]            ptch_rt_q, ptch_rt_d;
  logic [26:0]            ptch_int_q, ptch_int_d;
  logic signed [15:0]     az_comp, ptch_acc, ptch_cur;
  logic signed [25:0]     prod;
  logic [26:0]            fusion;
  logic                   unused_bits;

  assign int_rise   = int_ff2_q & ~int_ff3_q;
  assign timer_nxt  = timer_q + INIT_BITS'(1);
  // wrt is registered, so it fires on the edge that makes the timer all-ones
  assign timer_full = &timer_nxt;

  assign az_comp  = {az_hi_q, az_lo_q} - AZ_OFFSET;
  assign prod     = az_comp * 26'sd327;
  assign ptch_acc = {{3{prod[25]}}, prod[25:13]};
  assign ptch_cur = ptch_int_q[26:11];
  assign fusion   = (ptch_acc > ptch_cur) ? 27'd1024 : -27'd1024;

  assign unused_bits = ^{resp[15:8], prod[12:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:     if (timer_full) state_d = CFG1;
      CFG1:     if (done)       state_d = CFG2;
      CFG2:     if (done)       state_d = CFG3;
      CFG3:     if (done)       state_d = WAIT_INT;
      WAIT_INT: if (int_rise)   state_d = RD_RTL;
      RD_RTL:   if (done)       state_d = RD_RTH;
      RD_RTH:   if (done)       state_d = RD_AZL;
      RD_AZL:   if (done)       state_d = RD_AZH;
      RD_AZH:   if (done)       state_d = UPDATE;
      UPDATE:                   state_d = WAIT_INT;
      default:                  state_d = INIT;
    endcase
  end

  always_comb begin
    wrt_d      = 1'b0;
    cmd_d      = cmd_q;
    timer_d    = timer_q;
    rate_lo_d  = rate_lo_q;
    rate_hi_d  = rate_hi_q;
    az_lo_d    = az_lo_q;
    az_hi_d    = az_hi_q;
    ptch_rt_d  = ptch_rt_q;
    ptch_int_d = ptch_int_q;
    vld        = 1'b0;
    case (state_q)
      INIT: begin
        timer_d = timer_nxt;
        if (timer_full) begin wrt_d = 1'b1; cmd_d = 16'h0D02; end
      end
      CFG1:     if (done)     begin wrt_d = 1'b1; cmd_d = 16'h1053; end
      CFG2:     if (done)     begin wrt_d = 1'b1; cmd_d = 16'h1150; end
      CFG3:     if (done)     begin wrt_d = 1'b1; cmd_d = 16'h1460; end
      WAIT_INT: if (int_rise) begin wrt_d = 1'b1; cmd_d = 16'hA200; end
      RD_RTL: if (done) begin
        rate_lo_d = resp[7:0]; wrt_d = 1'b1; cmd_d = 16'hA300;
      end
      RD_RTH: if (done) begin
        rate_hi_d = resp[7:0]; wrt_d = 1'b1; cmd_d = 16'hAC00;
      end
      RD_AZL: if (done) begin
        az_lo_d = resp[7:0]; wrt_d = 1'b1; cmd_d = 16'hAD00;
      end
      RD_AZH: if (done) begin
        az_hi_d   = resp[7:0];
        ptch_rt_d = {rate_hi_q, rate_lo_q} - PTCH_RT_OFFSET;
      end
      UPDATE: begin
        vld = 1'b1;
        // integrate the rate, then nudge toward the accelerometer tilt
        ptch_int_d = ptch_int_q - {{11{ptch_rt_q[15]}}, ptch_rt_q} + fusion;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_ff1_q  <= 1'b0;
      int_ff2_q  <= 1'b0;
      int_ff3_q  <= 1'b0;
      timer_q    <= '0;
      wrt_q      <= 1'b0;
      cmd_q      <= 16'h0000;
      rate_lo_q  <= 8'h00;
      rate_hi_q  <= 8'h00;
      az_lo_q    <= 8'h00;
      az_hi_q    <= 8'h00;
      ptch_rt_q  <= 16'h0000;
      ptch_int_q <= 27'd0;
    end else begin
      int_ff1_q  <= INT;
      int_ff2_q  <= int_ff1_q;
      int_ff3_q  <= int_ff2_q;
      timer_q    <= timer_d;
      wrt_q      <= wrt_d;
      cmd_q      <= cmd_d;
      rate_lo_q  <= rate_lo_d;
      rate_hi_q  <= rate_hi_d;
      az_lo_q    <= az_lo_d;
      az_hi_q    <= az_hi_d;
      ptch_rt_q  <= ptch_rt_d;
      ptch_int_q <= ptch_int_d;
    end
  end

  assign wrt     = wrt_q;
  assign cmd     = cmd_q;
  assign ptch_rt = ptch_rt_q;
  assign ptch    = ptch_cur;

endmodule

// File: tb/tb_imu_ptch_intf.sv
// Directed bench for imu_ptch_intf with a simple SPI responder returning done 5 cycles after each wrt.
module tb_imu_ptch_intf;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        INT = 1'b0;
  logic        done = 1'b0;
  logic [15:0] resp = 16'h0000;
  logic        wrt, vld;
  logic [15:0] cmd, ptch_rt, ptch;

  int n_chk = 0, n_fail = 0;
  int wrt_cnt = 0, vld_cnt = 0, wrt_wide = 0;
  int v0, w0;
  logic wrt_prev = 1'b0;
  logic [7:0] rd_b [4];

  always #5 clk = ~clk;

  imu_ptch_intf #(.INIT_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .INT(INT), .done(done), .resp(resp),
    .wrt(wrt), .cmd(cmd), .ptch_rt(ptch_rt), .ptch(ptch), .vld(vld)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (wrt) wrt_cnt++;
    if (wrt && wrt_prev) wrt_wide++;
    if (vld) vld_cnt++;
    wrt_prev = wrt;
  end

  // SPI responder: the byte returned depends on the register read
  initial begin
    logic [7:0] b;
    forever begin
      @(posedge clk); #1;
      while (wrt) begin
        case (cmd)
          16'hA200: b = rd_b[0];
          16'hA300: b = rd_b[1];
          16'hAC00: b = rd_b[2];
          16'hAD00: b = rd_b[3];
          default:  b = 8'h00;
        endcase
        repeat (5) @(posedge clk);
        #1; done = 1'b1; resp = {8'hEE, b};
        @(posedge clk);
        #1; done = 1'b0; resp = 16'h0000;
      end
    end
  end

  task automatic wait_wrt(input string tag, input logic [15:0] exp_cmd, input int exp_cyc);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 200) begin
      @(posedge clk); #1;
      n++;
      seen = wrt;
    end
    chk({tag, " seen"}, seen, 1);
    chk({tag, " cmd"}, cmd, exp_cmd);
    chk({tag, " cyc"}, n, exp_cyc);
  endtask

  task automatic wait_vld(input string tag);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 200) begin
      @(posedge clk); #1;
      n++;
      seen = vld;
    end
    chk({tag, " vld seen"}, seen, 1);
    chk({tag, " vld cyc"}, n, 6);
  endtask

  task automatic do_init(input string tag);
    wait_wrt({tag, " 0D02"}, 16'h0D02, 15);
    wait_wrt({tag, " 1053"}, 16'h1053, 6);
    wait_wrt({tag, " 1150"}, 16'h1150, 6);
    wait_wrt({tag, " 1460"}, 16'h1460, 6);
  endtask

  task automatic run_sample(input string tag, input bit int_glitch);
    INT = 1'b0;
    repeat (4) @(posedge clk);
    #1; INT = 1'b1;
    wait_wrt({tag, " A200"}, 16'hA200, 3);
    wait_wrt({tag, " A300"}, 16'hA300, 6);
    if (int_glitch) INT = 1'b0;
    wait_wrt({tag, " AC00"}, 16'hAC00, 6);
    if (int_glitch) INT = 1'b1;
    wait_wrt({tag, " AD00"}, 16'hAD00, 6);
    wait_vld(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_b = '{8'h50, 8'h01, 8'hA0, 8'h00};
    repeat (3) @(posedge clk);
    #1;
    chk("rst wrt", wrt, 0);
    chk("rst cmd", cmd, 16'h0000);
    chk("rst vld", vld, 0);
    chk("rst ptch_rt", ptch_rt, 16'h0000);
    chk("rst ptch", ptch, 16'h0000);
    @(negedge clk) rst_n = 1'b1;
    do_init("init1");
    repeat (20) @(posedge clk);
    #1;
    chk("no vld before INT", vld_cnt, 0);

    // INT held high: one read sequence, one vld
    run_sample("s1", 1'b0);
    chk("s1 ptch_rt", ptch_rt, 16'h0100);
    chk("s1 ptch old", ptch, 16'h0000);
    @(posedge clk); #1;
    chk("s1 ptch new", ptch, 16'hFFFF);
    chk("s1 vld width", vld, 0);
    repeat (40) @(posedge clk);
    #1;
    chk("s1 wrt total", wrt_cnt, 8);
    chk("s1 vld total", vld_cnt, 1);

    // restart from zero accumulator for the positive fusion case
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    do_init("init2");
    rd_b = '{8'h50, 8'h00, 8'hA0, 8'h20};
    run_sample("s2", 1'b0);
    chk("s2 ptch_rt", ptch_rt, 16'h0000);
    @(posedge clk); #1;
    chk("s2 ptch", ptch, 16'h0000);
    run_sample("s3", 1'b0);
    @(posedge clk); #1;
    chk("s3 ptch", ptch, 16'h0001);

    // INT edge during RD_AZL is dropped; rate 0 wraps to -80
    rd_b = '{8'h00, 8'h00, 8'hA0, 8'h20};
    v0 = vld_cnt;
    w0 = wrt_cnt;
    run_sample("s4", 1'b1);
    chk("s4 ptch_rt wrap", ptch_rt, 16'hFFB0);
    chk("s4 ptch old", ptch, 16'h0001);
    @(posedge clk); #1;
    chk("s4 ptch new", ptch, 16'h0001);
    repeat (40) @(posedge clk);
    #1;
    chk("s4 single vld", vld_cnt - v0, 1);
    chk("s4 four reads", wrt_cnt - w0, 4);

    // reset while the A300 read is in flight
    INT = 1'b0;
    repeat (4) @(posedge clk);
    #1; INT = 1'b1;
    wait_wrt("r5 A200", 16'hA200, 3);
    wait_wrt("r5 A300", 16'hA300, 6);
    rst_n = 1'b0;
    #1;
    chk("r5 wrt", wrt, 0);
    chk("r5 cmd", cmd, 16'h0000);
    chk("r5 ptch", ptch, 16'h0000);
    chk("r5 ptch_rt", ptch_rt, 16'h0000);
    @(negedge clk) rst_n = 1'b1;
    v0 = vld_cnt;
    do_init("init3");
    repeat (20) @(posedge clk);
    #1;
    chk("r5 no vld", vld_cnt - v0, 0);
    chk("wrt pulse width", wrt_wide, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
